// File: rtl/ntt_fifo_port.sv
// ntt_fifo_port
//   Valid/ready adapter wrapped around the flagless first-word-fall-through
//   FIFO of an MDC NTT delay line. It drives the FIFO write strobe and data
//   directly from the upstream handshake, issues FIFO reads against a credit
//   budget, and catches the read data DELAY cycles later in a small circular
//   skid buffer that feeds the downstream port.
//
// Parameters
//   LOGQ   data width (must match the FIFO)
//   LOGN   log2 of FIFO depth
//   DELAY  FIFO read latency, 1 or 2
//
// Ports
//   clk, rst              clock, synchronous active-high reset (shared with FIFO)
//   s_valid/s_data/s_ready  upstream stream
//   m_valid/m_data/m_ready  downstream stream
//   fifo_wr/fifo_din      FIFO write side
//   fifo_rd/fifo_dout     FIFO read side
//   level                 words held: FIFO storage + reads in flight + skid
//   full / empty          ~s_ready / level == 0
//   err                   sticky protocol error
//
// Optional feature: define NTT_FIFO_PORT_PROTO_CHK_EN to build the upstream
// protocol checker behind err; otherwise err is tied low.

module ntt_fifo_port #(
  parameter int LOGQ  = 32,
  parameter int LOGN  = 8,
  parameter int DELAY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [LOGQ-1:0] s_data,
  output logic            s_ready,
  output logic            m_valid,
  output logic [LOGQ-1:0] m_data,
  input  logic            m_ready,
  output logic            fifo_wr,
  output logic [LOGQ-1:0] fifo_din,
  output logic            fifo_rd,
  input  logic [LOGQ-1:0] fifo_dout,
  output logic [LOGN+1:0] level,
  output logic            full,
  output logic            empty,
  output logic            err
);

  localparam int SKN = DELAY + 2;
  localparam int PW  = $clog2(SKN);
  localparam int OW  = $clog2(SKN + 1);
  localparam logic [LOGN:0]   DEPTH_C = {1'b1, {LOGN{1'b0}}};
  localparam logic [OW-1:0]   SKN_C   = OW'(SKN);
  localparam logic [PW-1:0]   SK_LAST = PW'(SKN - 1);

  logic [LOGN:0]   cnt;
  logic [DELAY-1:0] tag;
  logic [OW-1:0]   infl;
  logic [OW-1:0]   sk_occ;
  logic [PW-1:0]   sk_wp;
  logic [PW-1:0]   sk_rp;
  logic [LOGQ-1:0] sk_mem [SKN];
  logic            push;
  logic            pop;

  // cnt never exceeds DEPTH, so "not equal" is the same as "less than".
  // A read in the same cycle does not open space for a write.
  assign s_ready  = (cnt != DEPTH_C);
  assign full     = ~s_ready;
  assign fifo_wr  = s_valid & s_ready;
  assign fifo_din = s_data;
  assign empty    = (level == '0);

  assign m_valid = (sk_occ != '0);
  assign m_data  = sk_mem[sk_rp];
  assign push    = tag[DELAY-1];
  assign pop     = m_valid & m_ready;

  always_comb begin
    infl = '0;
    for (int i = 0; i < DELAY; i++) infl = infl + OW'(tag[i]);
  end

  // Credit rule: every word in flight already owns a skid slot, so the skid
  // can never overflow. Only registered state feeds this, keeping m_ready off
  // the read-issue path.
  assign fifo_rd = (cnt != '0) && ((sk_occ + infl) < SKN_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      tag   <= '0;
      level <= '0;
    end else begin
      cnt   <= cnt + (LOGN+1)'(fifo_wr) - (LOGN+1)'(fifo_rd);
      // Oldest tag sits in the MSB and drops out of the truncation.
      tag   <= DELAY'({tag, fifo_rd});
      // Words enter only via a write and leave only via a downstream pop, so
      // this tracks cnt + infl + sk_occ exactly.
      level <= level + (LOGN+2)'(fifo_wr) - (LOGN+2)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sk_wp  <= '0;
      sk_rp  <= '0;
      sk_occ <= '0;
      for (int i = 0; i < SKN; i++) sk_mem[i] <= '0;
    end else begin
      if (push) begin
        sk_mem[sk_wp] <= fifo_dout;
        sk_wp         <= (sk_wp == SK_LAST) ? '0 : sk_wp + 1'b1;
      end
      if (pop) sk_rp <= (sk_rp == SK_LAST) ? '0 : sk_rp + 1'b1;
      sk_occ <= sk_occ + OW'(push) - OW'(pop);
    end
  end

`ifdef NTT_FIFO_PORT_PROTO_CHK_EN
  logic            stall_q;
  logic [LOGQ-1:0] data_q;
  logic            err_q;
  logic            x_hit;

  always_comb begin
    x_hit = 1'b0;
`ifndef SYNTHESIS
    x_hit = $isunknown(m_ready);
`endif
  end

  // A stalled offer must be held unchanged until it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= s_valid & ~s_ready;
      data_q  <= s_data;
      if ((stall_q && (!s_valid || (s_data != data_q))) || x_hit) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_fifo_port.sv
// Bench for ntt_fifo_port: two instances (LOGN=3, DELAY=1 and DELAY=2), each
// with a behavioural FIFO of matching read latency. The reference model is a
// per-instance queue of accepted words: level must equal its size, and every
// downstream transfer must deliver its head.

module tb_ntt_fifo_port;

  localparam int LOGQ  = 32;
  localparam int LOGN  = 3;
  localparam int DEPTH = 8;
`ifdef NTT_FIFO_PORT_PROTO_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            sv     [2];
  logic [LOGQ-1:0] sd     [2];
  logic            mr     [2];
  logic            sr     [2];
  logic            mv     [2];
  logic [LOGQ-1:0] md     [2];
  logic            fwr    [2];
  logic [LOGQ-1:0] fdin   [2];
  logic            frd    [2];
  logic [LOGQ-1:0] fdout  [2];
  logic [LOGN+1:0] lvl    [2];
  logic            full_o [2];
  logic            empty_o[2];
  logic            err_o  [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = g + 1;
    logic [LOGQ-1:0] mem  [DEPTH];
    logic [LOGQ-1:0] pipe [D];
    logic [2:0]      wp, rp;

    ntt_fifo_port #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY(D)) u_dut (
      .clk(clk), .rst(rst),
      .s_valid(sv[g]), .s_data(sd[g]), .s_ready(sr[g]),
      .m_valid(mv[g]), .m_data(md[g]), .m_ready(mr[g]),
      .fifo_wr(fwr[g]), .fifo_din(fdin[g]),
      .fifo_rd(frd[g]), .fifo_dout(fdout[g]),
      .level(lvl[g]), .full(full_o[g]), .empty(empty_o[g]), .err(err_o[g])
    );

    // Flagless FIFO: read data appears D cycles after the read strobe.
    always_ff @(posedge clk) begin
      if (rst) begin
        wp <= '0;
        rp <= '0;
        for (int k = 0; k < D; k++) pipe[k] <= '0;
      end else begin
        if (fwr[g]) begin
          mem[wp] <= fdin[g];
          wp      <= wp + 3'd1;
        end
        if (frd[g]) rp <= rp + 3'd1;
        pipe[0] <= mem[rp];
        for (int k = 1; k < D; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign fdout[g] = pipe[D-1];
  end

  int              nvec = 0;
  int              nerr = 0;
  bit              live = 1'b0;
  bit              err_exp[2];
  logic [LOGQ-1:0] q[2][$];
  logic            obs_sr[2], obs_mv[2], obs_rd[2];
  logic [LOGQ-1:0] obs_md[2];

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0h, want %0h", nm, i, act, exp);
    end
  endtask

  // One clock cycle: sample away from the edge, compare against the model,
  // update the model with this cycle's transfers, then advance.
  task automatic tick();
    logic [LOGQ-1:0] e;
    #1;
    for (int i = 0; i < 2; i++) begin
      obs_sr[i] = sr[i];
      obs_mv[i] = mv[i];
      obs_md[i] = md[i];
      obs_rd[i] = frd[i];
      if (live) begin
        chk("level", i, lvl[i], q[i].size());
        chk("empty", i, empty_o[i], q[i].size() == 0);
        chk("full", i, full_o[i], !sr[i]);
        chk("fifo_wr", i, fwr[i], sv[i] & sr[i]);
        chk("fifo_din", i, fdin[i], sd[i]);
        chk("level_max", i, lvl[i] <= DEPTH + i + 3, 1);
        chk("err", i, err_o[i], err_exp[i]);
        chk("m_valid_without_data", i, mv[i] && q[i].size() == 0, 0);
        if (mv[i] && mr[i] && q[i].size() != 0) begin
          e = q[i].pop_front();
          chk("m_data", i, md[i], e);
        end
        if (rst) begin
          q[i].delete();
          err_exp[i] = 1'b0;
        end else if (sv[i] && sr[i]) begin
          q[i].push_back(sd[i]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0;
      mr[i] = 1'b1;
    end
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 100) begin
      tick();
      n++;
    end
    for (int i = 0; i < 2; i++) chk("drain", i, q[i].size(), 0);
  endtask

  initial begin
    int next, n, seen, sent[2];
    logic [LOGQ-1:0] got;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sd[i] = '0; mr[i] = 1'b0; err_exp[i] = 1'b0;
    end
    tick();
    tick();
    rst  = 1'b0;
    live = 1'b1;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      chk("rst_s_ready", i, sr[i], 1);
      chk("rst_m_valid", i, mv[i], 0);
      chk("rst_m_data", i, md[i], 0);
      chk("rst_fifo_wr", i, fwr[i], 0);
      chk("rst_fifo_rd", i, frd[i], 0);
      chk("rst_level", i, lvl[i], 0);
      chk("rst_full", i, full_o[i], 0);
      chk("rst_empty", i, empty_o[i], 1);
      chk("rst_err", i, err_o[i], 0);
    end

    // DELAY=1 streaming: words 1..20, first out at cycle 3, no gaps
    mr[0] = 1'b1;
    for (int k = 0; k < 26; k++) begin
      sv[0] = (k < 20);
      sd[0] = k + 1;
      tick();
      if (k < 20) chk("t1_s_ready", 0, obs_sr[0], 1);
      if (k < 3) chk("t1_latency", 0, obs_mv[0], 0);
      if (k >= 3 && k <= 22) begin
        chk("t1_m_valid", 0, obs_mv[0], 1);
        chk("t1_m_data", 0, obs_md[0], k - 2);
      end
    end
    drain();

    // DELAY=2 backpressure: 12 held, then words 1..12 back to back
    mr[1] = 1'b0;
    next  = 1;
    for (int k = 0; k < 30; k++) begin
      sv[1] = 1'b1;
      sd[1] = next;
      tick();
      if (obs_sr[1]) next++;
    end
    chk("t2_level", 1, lvl[1], 12);
    chk("t2_full", 1, full_o[1], 1);
    chk("t2_s_ready", 1, sr[1], 0);
    chk("t2_accepted", 1, next - 1, 12);
    mr[1] = 1'b1;
    for (int k = 0; k < 40 && next <= 20; k++) begin
      sv[1] = 1'b1;
      sd[1] = next;
      tick();
      if (obs_sr[1]) next++;
      if (k < 12) begin
        chk("t2_m_valid", 1, obs_mv[1], 1);
        chk("t2_m_data", 1, obs_md[1], k + 1);
      end
    end
    drain();

    // DELAY=1 full: write refused while the read proceeds, then accepted
    mr[0] = 1'b0;
    next  = 101;
    for (int k = 0; k < 30; k++) begin
      sv[0] = 1'b1;
      sd[0] = next;
      tick();
      if (obs_sr[0]) next++;
    end
    chk("t3_level", 0, lvl[0], 11);
    chk("t3_s_ready", 0, sr[0], 0);
    mr[0] = 1'b1;
    tick();
    chk("t3_a_s_ready", 0, obs_sr[0], 0);
    chk("t3_a_fifo_rd", 0, obs_rd[0], 0);
    tick();
    chk("t3_b_s_ready", 0, obs_sr[0], 0);
    chk("t3_b_fifo_rd", 0, obs_rd[0], 1);
    tick();
    chk("t3_c_s_ready", 0, obs_sr[0], 1);
    drain();

    // Reset mid-stream at level 9, then a lone word
    mr[0] = 1'b0;
    next  = 201;
    n     = 0;
    while (lvl[0] != 9 && n < 30) begin
      sv[0] = 1'b1;
      sd[0] = next;
      tick();
      if (obs_sr[0]) next++;
      n++;
    end
    chk("t5_level_pre", 0, lvl[0], 9);
    sv[0] = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_level", 0, lvl[0], 0);
    chk("t5_m_valid", 0, mv[0], 0);
    chk("t5_empty", 0, empty_o[0], 1);
    mr[0] = 1'b1;
    sv[0] = 1'b1;
    sd[0] = 32'hABCD;
    tick();
    sv[0] = 1'b0;
    seen  = 0;
    got   = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (obs_mv[0]) begin
        seen++;
        got = obs_md[0];
      end
    end
    chk("t5_count", 0, seen, 1);
    chk("t5_word", 0, got, 32'hABCD);
    drain();

    // Random traffic on both instances
    for (int i = 0; i < 2; i++) begin
      sent[i] = 0;
      sv[i]   = 1'b0;
    end
    n = 0;
    while ((sent[0] < 10000 || sent[1] < 10000 || q[0].size() != 0 || q[1].size() != 0)
           && n < 60000) begin
      for (int i = 0; i < 2; i++) begin
        if (!(sv[i] && !obs_sr[i])) begin
          sv[i] = (sent[i] < 10000) && ($urandom_range(3) != 0);
          sd[i] = $urandom;
        end
        mr[i] = $urandom_range(1);
      end
      tick();
      for (int i = 0; i < 2; i++) if (sv[i] && obs_sr[i]) sent[i]++;
      n++;
    end
    for (int i = 0; i < 2; i++) begin
      chk("t4_sent", i, sent[i], 10000);
      chk("t4_left", i, q[i].size(), 0);
    end
    drain();

    // Protocol violation: drop s_valid while stalled
    mr[0] = 1'b0;
    next  = 301;
    for (int k = 0; k < 30; k++) begin
      sv[0] = 1'b1;
      sd[0] = next;
      tick();
      if (obs_sr[0]) next++;
    end
    chk("t6_stalled", 0, sr[0], 0);
    sv[0] = 1'b0;
    tick();
    chk("t6_err_set", 0, err_o[0], CHK);
    err_exp[0] = CHK;
    for (int k = 0; k < 3; k++) tick();
    chk("t6_err_held", 0, err_o[0], CHK);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_err_cleared", 0, err_o[0], 0);
    chk("t6_level", 0, lvl[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
